// File: rtl/paralelo_serial_fifo_if.sv
// Symbol-side bus of the parallel-to-serial TX converter: producer handshake in, serial line and status out.
interface paralelo_serial_fifo_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] data_in;
   logic             valid_in;
   logic             ready_out;
   logic             data_out;
   logic             sym_start;
   logic             idle_out;
   logic [CW-1:0]    fifo_count;

   modport master (
      output data_in, valid_in,
      input  ready_out, data_out, sym_start, idle_out, fifo_count
   );

   modport slave (
      input  data_in, valid_in,
      output ready_out, data_out, sym_start, idle_out, fifo_count
   );
endinterface

// File: rtl/paralelo_serial_fifo.sv
// FIFO-buffered parallel-to-serial converter, MSB-first, with IDLE_SYM filler on empty boundaries.
// Optional macro PS_IDLE_CNT_EN adds a saturating 16-bit idle_cnt output counting inserted fillers.
module paralelo_serial_fifo #(
   parameter int               WIDTH    = 8,
   parameter int               DEPTH    = 4,
   parameter logic [WIDTH-1:0] IDLE_SYM = 8'hBC
) (
   input  logic                 clk_4f,
   input  logic                 reset,
`ifdef PS_IDLE_CNT_EN
   output logic [15:0]          idle_cnt,
`endif
   paralelo_serial_fifo_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int BW = $clog2(WIDTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [BW-1:0]    bit_cnt;
   logic [WIDTH-2:0] shreg;
   logic             data_out_q;
   logic             sym_start_q;
   logic             idle_out_q;

   logic             ready;
   logic             push;
   logic             pop;
   logic             boundary;
   logic [WIDTH-1:0] head;
   logic [BW-1:0]    bit_idx;

   // Pop decision uses the pre-edge count, so a word written this edge is never popped this edge.
   always_comb begin
      ready    = (count < CW'(DEPTH));
      push     = bus.valid_in && ready;
      boundary = (bit_cnt == BW'(WIDTH - 1));
      pop      = boundary && (count != '0);
      head     = mem[rd_ptr];
      bit_idx  = BW'(WIDTH - 2) - bit_cnt;
   end

   always_ff @(posedge clk_4f) begin
      if (push) begin
         mem[wr_ptr] <= bus.data_in;
      end
   end

   always_ff @(posedge clk_4f) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         bit_cnt     <= BW'(WIDTH - 1);
         shreg       <= '0;
         data_out_q  <= 1'b0;
         sym_start_q <= 1'b0;
         idle_out_q  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         if (boundary) begin
            bit_cnt     <= '0;
            sym_start_q <= 1'b1;
            if (pop) begin
               shreg      <= head[WIDTH-2:0];
               data_out_q <= head[WIDTH-1];
               idle_out_q <= 1'b0;
            end else begin
               shreg      <= IDLE_SYM[WIDTH-2:0];
               data_out_q <= IDLE_SYM[WIDTH-1];
               idle_out_q <= 1'b1;
            end
         end else begin
            bit_cnt     <= bit_cnt + 1'b1;
            sym_start_q <= 1'b0;
            data_out_q  <= shreg[bit_idx];
         end
      end
   end

`ifdef PS_IDLE_CNT_EN
   always_ff @(posedge clk_4f) begin
      if (reset) begin
         idle_cnt <= '0;
      end else if (boundary && !pop && (idle_cnt != 16'hFFFF)) begin
         idle_cnt <= idle_cnt + 16'd1;
      end
   end
`endif

   assign bus.ready_out  = ready;
   assign bus.data_out   = data_out_q;
   assign bus.sym_start  = sym_start_q;
   assign bus.idle_out   = idle_out_q;
   assign bus.fifo_count = count;

endmodule

// File: tb/tb_paralelo_serial_fifo.sv
// Scoreboard bench: a queue-level model predicts each symbol; a monitor reassembles serial symbols and compares.
module tb_paralelo_serial_fifo;
   localparam int W = 8;
   localparam int D = 4;
   localparam logic [W-1:0] IDLE = 8'hBC;

   logic clk_4f = 1'b0;
   logic reset  = 1'b1;

   paralelo_serial_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

`ifdef PS_IDLE_CNT_EN
   logic [15:0] idle_cnt;
`endif

   paralelo_serial_fifo #(.WIDTH(W), .DEPTH(D), .IDLE_SYM(IDLE)) dut (
      .clk_4f (clk_4f),
      .reset  (reset),
`ifdef PS_IDLE_CNT_EN
      .idle_cnt (idle_cnt),
`endif
      .bus    (bus)
   );

   always #5 clk_4f = ~clk_4f;

   int vectors    = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: queue of accepted words, one expected symbol per boundary.
   typedef struct {
      logic [W-1:0] sym;
      bit           idle;
   } exp_t;

   logic [W-1:0] wq [$];
   exp_t         eq [$];
   int           m_pos      = W - 1;
   bit           m_on       = 1'b0;
   bit           m_in_rst   = 1'b1;
   bit           m_acc      = 1'b0;
   bit           m_take     = 1'b0;
   logic [W-1:0] m_sym      = '0;
   bit           m_idle     = 1'b0;
   logic [15:0]  m_idle_cnt = '0;

   always @(posedge clk_4f) begin
      m_acc = 1'b0;
      if (reset) begin
         wq.delete();
         eq.delete();
         m_pos      = W - 1;
         m_on       = 1'b1;
         m_in_rst   = 1'b1;
         m_idle     = 1'b0;
         m_idle_cnt = '0;
      end else if (m_on) begin
         m_in_rst = 1'b0;
         m_take   = bus.valid_in && (wq.size() < D);
         if (m_pos == W - 1) begin
            m_pos = 0;
            if (wq.size() > 0) begin
               m_sym  = wq.pop_front();
               m_idle = 1'b0;
            end else begin
               m_sym  = IDLE;
               m_idle = 1'b1;
               if (m_idle_cnt != 16'hFFFF) m_idle_cnt = m_idle_cnt + 16'd1;
            end
            eq.push_back('{m_sym, m_idle});
         end else begin
            m_pos++;
         end
         if (m_take) wq.push_back(bus.data_in);
         m_acc = m_take;
      end
   end

   // Monitor: rebuilds each serial symbol from data_out and checks it against the scoreboard.
   bit           coll  = 1'b0;
   int           nb    = 0;
   logic [W-1:0] asym  = '0;
   logic         idle0 = 1'b0;
   exp_t         e;

   always @(negedge clk_4f) begin
      if (m_on) begin
         chk("fifo_count", 32'(bus.fifo_count), 32'(wq.size()));
         chk("ready_out", 32'(bus.ready_out), 32'(wq.size() < D));
         if (m_in_rst) begin
            chk("rst_data_out", 32'(bus.data_out), 32'd0);
            chk("rst_sym_start", 32'(bus.sym_start), 32'd0);
            chk("rst_idle_out", 32'(bus.idle_out), 32'd0);
            coll = 1'b0;
         end else begin
            chk("sym_start", 32'(bus.sym_start), 32'(m_pos == 0));
`ifdef PS_IDLE_CNT_EN
            chk("idle_cnt", 32'(idle_cnt), 32'(m_idle_cnt));
`endif
            if (bus.sym_start) begin
               coll  = 1'b1;
               nb    = 1;
               asym  = {{(W-1){1'b0}}, bus.data_out};
               idle0 = bus.idle_out;
            end else if (coll) begin
               asym = {asym[W-2:0], bus.data_out};
               nb++;
               chk("idle_hold", 32'(bus.idle_out), 32'(idle0));
            end
            if (coll && nb == W) begin
               coll = 1'b0;
               if (eq.size() == 0) begin
                  miscompares++;
                  $display("FAIL symbol: got %0h expected none queued at %0t", asym, $time);
               end else begin
                  e = eq.pop_front();
                  chk("symbol", 32'(asym), 32'(e.sym));
                  chk("idle_flag", 32'(idle0), 32'(e.idle));
               end
            end
         end
      end
   end

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk_4f);
   endtask

   // Holds valid_in high until every word has been accepted by the model's occupancy rule.
   task automatic push_words(input logic [W-1:0] words [$]);
      int i = 0;
      int guard = 0;
      if (words.size() == 0) return;
      @(negedge clk_4f);
      bus.valid_in = 1'b1;
      bus.data_in  = words[0];
      while (i < words.size() && guard < 400) begin
         @(negedge clk_4f);
         guard++;
         if (m_acc) begin
            i++;
            if (i < words.size()) bus.data_in = words[i];
            else bus.valid_in = 1'b0;
         end
      end
      if (i < words.size()) begin
         miscompares++;
         bus.valid_in = 1'b0;
         $display("FAIL push_timeout: got %0d accepted expected %0d", i, words.size());
      end
   endtask

   task automatic random_phase(input int cycles, input int pct);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk_4f);
         bus.valid_in = ($urandom_range(0, 99) < pct);
         bus.data_in  = W'($urandom);
      end
      @(negedge clk_4f);
      bus.valid_in = 1'b0;
   endtask

   initial begin
      logic [W-1:0] words [$];
      int guard;
      bus.valid_in = 1'b0;
      bus.data_in  = '0;
      idle_cnt_wait: begin
         idle_cycles(3);
      end
      reset = 1'b0;
      idle_cycles(3 * W + 2);

      words = '{8'hA5};
      push_words(words);
      idle_cycles(4 * W);

      words = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      push_words(words);
      idle_cycles(8 * W);

      words = '{8'h3C, 8'hC3, 8'h5A};
      push_words(words);
      guard = 0;
      while (!(m_pos == 3 && !m_idle && !m_in_rst) && guard < 200) begin
         @(negedge clk_4f);
         guard++;
      end
      if (guard >= 200) begin
         miscompares++;
         $display("FAIL reset_mid_symbol: got no data bit 3 expected one within %0d cycles", guard);
      end
      reset = 1'b1;
      @(negedge clk_4f);
      reset = 1'b0;
      idle_cycles(4 * W);

      random_phase(1500, 10);
      idle_cycles(6 * W);
      random_phase(1500, 45);
      idle_cycles(6 * W);

      @(negedge clk_4f);
      reset = 1'b1;
      @(negedge clk_4f);
      reset = 1'b0;
      random_phase(800, 25);
      idle_cycles(8 * W);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
